// File: rtl/fsub_pkg.sv
// Shared types and sizing helpers for the chunked subtractor and its CLA adder.
// Operand width, chunk width and chunk count are all powers of the CLA fan-in.
package fsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // base**exp for elaboration-time sizing; exp is small, so a loop is fine
   function automatic int fsub_width(input int base, input int exp);
      int r;
      r = 1;
      for (int i = 0; i < exp; i++) begin
         r = r * base;
      end
      return r;
   endfunction

   function automatic int fsub_idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fadd.sv
// Combinational carry-lookahead adder: sum = in1 + in2 + cin over input_size**depth bits.
// Carries come from a parallel-prefix (Kogge-Stone) generate/propagate tree.
module fadd
   import fsub_pkg::*;
#(
   parameter int input_size = 2,
   parameter int depth      = 3,
   localparam int W = fsub_width(input_size, depth)
) (
   input  logic [W-1:0] in1,
   input  logic [W-1:0] in2,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   logic [W:0] w_c;

   always_comb begin
      logic [W-1:0] v_g, v_p, v_gn, v_pn;
      v_g = in1 & in2;
      v_p = in1 ^ in2;
      // After the loop, v_g[i]/v_p[i] span bits i..0
      for (int l = 0; (1 << l) < W; l++) begin
         v_gn = v_g;
         v_pn = v_p;
         for (int i = (1 << l); i < W; i++) begin
            v_gn[i] = v_g[i] | (v_p[i] & v_g[i - (1 << l)]);
            v_pn[i] = v_p[i] & v_p[i - (1 << l)];
         end
         v_g = v_gn;
         v_p = v_pn;
      end
      w_c[0] = cin;
      for (int i = 0; i < W; i++) begin
         w_c[i+1] = v_g[i] | (v_p[i] & cin);
      end
   end

   assign sum  = in1 ^ in2 ^ w_c[W-1:0];
   assign cout = w_c[W];

endmodule

// File: rtl/fsub_seq.sv
// Multi-cycle subtractor: diff = a - b - bin, one C-bit chunk per clock through a
// narrow fadd evaluating a + ~b + ~borrow, with valid/ready on both sides.
module fsub_seq
   import fsub_pkg::*;
#(
   parameter int input_size  = 2,
   parameter int depth       = 5,
   parameter int chunk_depth = 3,
   localparam int W = fsub_width(input_size, depth),
   localparam int C = fsub_width(input_size, chunk_depth)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         bin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] diff,
   output logic         bout,
   output logic         ovf
);

   localparam int N     = W / C;
   localparam int IDX_W = fsub_idx_w(N);

   state_t             r_state;
   logic [W-1:0]       r_a, r_b, r_diff;
   logic               r_borrow, r_bout, r_ovf, r_out_valid, r_in_ready;
   logic [IDX_W-1:0]   r_idx;

   logic [C-1:0]       w_a_chunks [N];
   logic [C-1:0]       w_b_chunks [N];
   logic [C-1:0]       w_a_chunk, w_b_chunk, w_sum;
   logic               w_cout;

   for (genvar gi = 0; gi < N; gi++) begin : g_chunk
      assign w_a_chunks[gi] = r_a[gi*C +: C];
      assign w_b_chunks[gi] = r_b[gi*C +: C];
   end

   assign w_a_chunk = w_a_chunks[r_idx];
   assign w_b_chunk = w_b_chunks[r_idx];

   fadd #(
      .input_size (input_size),
      .depth      (chunk_depth)
   ) u_fadd (
      .in1  (w_a_chunk),
      .in2  (~w_b_chunk),
      .cin  (~r_borrow),
      .sum  (w_sum),
      .cout (w_cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_diff      <= '0;
         r_borrow    <= 1'b0;
         r_idx       <= '0;
         r_bout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_in_ready <= 1'b1;
               if (in_valid && r_in_ready) begin
                  r_a        <= a;
                  r_b        <= b;
                  r_borrow   <= bin;
                  r_idx      <= '0;
                  r_diff     <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= BUSY;
               end
            end
            BUSY: begin
               for (int i = 0; i < N; i++) begin
                  if (r_idx == IDX_W'(i)) r_diff[i*C +: C] <= w_sum;
               end
               r_borrow <= ~w_cout;
               if (r_idx == IDX_W'(N - 1)) begin
                  // w_sum[C-1] is the sign bit of diff being written this cycle
                  r_bout      <= ~w_cout;
                  r_ovf       <= (r_a[W-1] != r_b[W-1]) && (w_sum[C-1] != r_a[W-1]);
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign diff      = r_diff;
   assign bout      = r_bout;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_fsub_seq.sv
// Directed and randomized checks of fsub_seq against hand-computed values and an
// a-b-bin reference, including backpressure, reset abort and latency.
module tb_fsub_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        bin = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] diff;
   logic        bout;
   logic        ovf;

   int n_checks = 0;
   int n_pass   = 0;

   fsub_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // Wait for in_ready, present one operand set for exactly one accept edge
   task automatic start_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                           input logic vbin);
      int t;
      t = 0;
      while (!in_ready && t < 20) begin
         tick();
         t++;
      end
      check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
      a        = va;
      b        = vb;
      bin      = vbin;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check({tag, ".busy_ov"}, 64'(out_valid), 64'd0);
   endtask

   // Count edges after the accept edge until out_valid; must be exactly N = 4
   task automatic wait_done(input string tag);
      int lat;
      lat = 1;
      while (!out_valid && lat < 20) begin
         tick();
         if (!out_valid) lat++;
      end
      check({tag, ".latency"}, 64'(lat), 64'd4);
   endtask

   task automatic check_res(input string tag, input logic [31:0] ed, input logic eb,
                            input logic eo);
      check({tag, ".diff"}, 64'(diff), 64'(ed));
      check({tag, ".bout"}, 64'(bout), 64'(eb));
      check({tag, ".ovf"},  64'(ovf),  64'(eo));
   endtask

   task automatic release_op(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, ".ov_drop"}, 64'(out_valid), 64'd0);
      check({tag, ".rdy_back"}, 64'(in_ready), 64'd1);
   endtask

   task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic vbin, input logic [31:0] ed, input logic eb,
                         input logic eo, input int hold);
      start_op(tag, va, vb, vbin);
      wait_done(tag);
      check_res(tag, ed, eb, eo);
      for (int h = 0; h < hold; h++) begin
         tick();
         check({tag, ".hold_ov"}, 64'(out_valid), 64'd1);
         check({tag, ".hold_diff"}, 64'(diff), 64'(ed));
      end
      release_op(tag);
      $display("op %s a=%08h b=%08h bin=%0d -> diff=%08h bout=%0d ovf=%0d",
               tag, va, vb, vbin, diff, bout, ovf);
   endtask

   initial begin
      logic [32:0] wide;
      logic [31:0] ra, rb, ed;
      logic        rbin, eo;

      // Reset state
      #2;
      check("rst.in_ready", 64'(in_ready), 64'd0);
      check("rst.out_valid", 64'(out_valid), 64'd0);
      check("rst.diff", 64'(diff), 64'd0);
      check("rst.bout", 64'(bout), 64'd0);
      check("rst.ovf", 64'(ovf), 64'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("rel.in_ready", 64'(in_ready), 64'd1);

      // Directed vectors
      run_op("d_basic",  32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 0);
      run_op("d_ripple", 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
      run_op("d_ovf_n",  32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1);
      run_op("d_ovf_p",  32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 0);
      run_op("d_cross",  32'h0000_0100, 32'h0000_00FF, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 0);
      run_op("d_binonly", 32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
      run_op("d_equal",  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 0);

      // Backpressure with in_valid pulsing while the result is held
      start_op("bp", 32'h0000_1234, 32'h0000_0034, 1'b0);
      wait_done("bp");
      for (int h = 0; h < 3; h++) begin
         in_valid = (h != 1);
         a        = 32'hFFFF_0000;
         b        = 32'h0000_0001;
         tick();
         check("bp.ov", 64'(out_valid), 64'd1);
         check("bp.rdy", 64'(in_ready), 64'd0);
         check_res("bp", 32'h0000_1200, 1'b0, 1'b0);
      end
      in_valid = 1'b0;
      release_op("bp");
      check("bp.held_diff", 64'(diff), 64'h1200);
      tick();
      check("bp.no_capture", 64'(out_valid), 64'd0);
      $display("op bp a=00001234 b=00000034 bin=0 -> diff=%08h held under backpressure", diff);

      // Reset abort in the middle of BUSY (chunk index 2)
      start_op("rab", 32'h1234_5678, 32'h0101_0101, 1'b0);
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("rab.out_valid", 64'(out_valid), 64'd0);
      check("rab.diff", 64'(diff), 64'd0);
      check("rab.in_ready", 64'(in_ready), 64'd0);
      tick();
      check("rab.in_ready_hold", 64'(in_ready), 64'd0);
      rst = 1'b0;
      tick();
      check("rab.in_ready_rel", 64'(in_ready), 64'd1);
      tick();
      tick();
      tick();
      tick();
      check("rab.no_partial", 64'(out_valid), 64'd0);
      $display("op rab aborted by reset at chunk 2");

      // Randomized operands with random backpressure against a-b-bin model
      for (int i = 0; i < 1000; i++) begin
         ra   = $urandom;
         rb   = $urandom;
         rbin = 1'($urandom_range(0, 1));
         if (i % 10 == 0) rb = ra;
         if (i % 10 == 1) rb = ra + 32'd1;
         wide = {1'b0, ra} - {1'b0, rb} - {32'd0, rbin};
         ed   = wide[31:0];
         eo   = (ra[31] != rb[31]) && (ed[31] != ra[31]);
         for (int d = $urandom_range(0, 2); d > 0; d--) tick();
         run_op($sformatf("r%0d", i), ra, rb, rbin, ed, wide[32], eo,
                int'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global watchdog so a stuck design still reaches a verdict
   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
